// File: rtl/store_bus_monitor.sv
// Store-bus monitor: decides PASS/FAIL/TIMEOUT from tohost-style stores, counts stores/cycles, traces stores.
// Latency: a store sampled at edge N is reflected in status and trace outputs after edge N.
// Backpressure: trace port is valid/ready; stores arriving while the trace FIFO is full are dropped and flagged.

// Generic FWFT FIFO: power-of-two depth, occupancy 0..DEPTH, head reads zero when empty.
// Latency: a push at edge N is visible at the head after edge N.
// Backpressure: push_rdy is low only when full with no pop on the same edge.
module sbm_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_fire;
    logic          pop_fire;

    assign pop_vld   = (count != '0);
    assign pop_fire  = pop_vld && pop_rdy;
    // A simultaneous pop frees a slot, so a full FIFO still accepts that push.
    assign push_rdy  = (count != FULL) || pop_fire;
    assign push_fire = push_vld && push_rdy;
    assign pop_dat   = pop_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_fire, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_ptr] <= push_dat;
    end
endmodule

module store_bus_monitor #(
    parameter logic [31:0] PASS_ADDR      = 32'd100,
    parameter logic [31:0] PASS_DATA      = 32'd25,
    parameter logic [31:0] FAIL_ADDR      = 32'd104,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd200000,
    parameter int          FIFO_DEPTH     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAddr,
    input  logic [31:0] WriteData,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic        trace_overflow,
    output logic [31:0] store_count,
    output logic [31:0] cycle_count,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout
);
    typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } trace_t;

    state_t      state_q;
    state_t      state_d;
    logic        in_run;
    logic        store_acc;
    logic [31:0] cycle_next;
    logic        timeout_hit;
    logic        fifo_push_rdy;
    trace_t      push_entry;
    trace_t      head_entry;

    assign in_run      = (state_q == S_RUN);
    assign store_acc   = MemWrite && in_run;
    assign cycle_next  = (&cycle_count) ? cycle_count : cycle_count + 32'd1;
    assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (cycle_next == TIMEOUT_CYCLES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_RUN;
        else       state_q <= state_d;
    end

    // Store decisions take priority over a timeout landing on the same edge.
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        pass    = 1'b0;
        fail    = 1'b0;
        timeout = 1'b0;
        if (state_q == S_RUN) begin
            if (store_acc && (DataAddr == PASS_ADDR))
                state_d = (WriteData == PASS_DATA) ? S_PASS : S_FAIL;
            else if (store_acc && (DataAddr == FAIL_ADDR))
                state_d = S_FAIL;
            else if (timeout_hit)
                state_d = S_TIMEOUT;
        end
        done    = (state_q != S_RUN);
        pass    = (state_q == S_PASS);
        fail    = (state_q == S_FAIL);
        timeout = (state_q == S_TIMEOUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count    <= '0;
            store_count    <= '0;
            trace_overflow <= 1'b0;
        end else begin
            if (in_run)                      cycle_count    <= cycle_next;
            if (store_acc)                   store_count    <= store_count + 32'd1;
            if (store_acc && !fifo_push_rdy) trace_overflow <= 1'b1;
        end
    end

    assign push_entry = '{addr: DataAddr, data: WriteData};

    sbm_fifo #(
        .W     ($bits(trace_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_trace_fifo (
        .clk      (clk),
        .rst      (reset),
        .push_vld (store_acc),
        .push_rdy (fifo_push_rdy),
        .push_dat (push_entry),
        .pop_vld  (trace_valid),
        .pop_rdy  (trace_ready),
        .pop_dat  (head_entry)
    );

    assign trace_addr = head_entry.addr;
    assign trace_data = head_entry.data;
endmodule

// File: doc/store_bus_monitor.md
Name: store_bus_monitor

Overview:
- Sits directly downstream of the CPU top's data-memory store bus (MemWrite, DataAddr, WriteData) and consumes every store.
- Decides run outcome in hardware from tohost-style addresses: PASS, FAIL or TIMEOUT.
- Keeps store and cycle counters for the outcome.
- Buffers a store trace in a FIFO, drained over a valid/ready port.
- Replaces ad-hoc pass/timeout checking in benches; also usable on FPGA with LEDs or UART on the outputs.

Parameters:
PASS_ADDR, 32'd100, store address that signals the end of a run
PASS_DATA, 32'd25, data at PASS_ADDR that means pass; any other data there means fail
FAIL_ADDR, 32'd104, any store here means fail, regardless of data
TIMEOUT_CYCLES, 200000, cycles in RUN before TIMEOUT; 0 disables timeout
FIFO_DEPTH, 8, trace FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
MemWrite  input  1  store strobe from CPU
DataAddr  input  32  store address
WriteData  input  32  store data
trace_valid  output  1  FIFO head valid
trace_ready  input  1  consumer accepts head
trace_addr  output  32  head address; 0 when empty
trace_data  output  32  head data; 0 when empty
trace_overflow  output  1  sticky: a store was dropped because the FIFO was full
store_count  output  32  stores accepted in RUN
cycle_count  output  32  rising edges spent in RUN
done  output  1  state != RUN
pass  output  1  state == PASS
fail  output  1  state == FAIL
timeout  output  1  state == TIMEOUT

Behaviour:
- Reset values: state RUN, FIFO empty, trace_valid 0, trace_addr/trace_data 0, trace_overflow 0, counters 0, done/pass/fail/timeout 0.
- Reset mid-operation: takes effect immediately, without waiting for a clock edge. Same values as above; FIFO contents are discarded.
- All outputs are registered or decoded from registered state. A store sampled at edge N is visible in the outputs after edge N.
- States: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal and sticky until reset.
- RUN transitions on a store (MemWrite=1 at the edge):
  - DataAddr==PASS_ADDR and WriteData==PASS_DATA -> PASS.
  - DataAddr==PASS_ADDR and any other data -> FAIL.
  - DataAddr==FAIL_ADDR -> FAIL.
  - Any other address -> stay in RUN.
- cycle_count: increments on every edge while in RUN, frozen in terminal states, saturates at all-ones.
- TIMEOUT: taken on the edge where the incremented cycle_count equals TIMEOUT_CYCLES (TIMEOUT_CYCLES != 0); cycle_count then reads TIMEOUT_CYCLES.
- A terminating store and the timeout on the same edge: the store decision wins.
- store_count: increments for every store sampled in RUN, including the terminating one. Stores in terminal states are ignored: not counted, not traced.
- Trace FIFO, first-word fall-through:
  - Every store accepted in RUN is pushed as {DataAddr, WriteData}.
  - Push to empty FIFO: trace_valid=1 after that edge.
  - Pop when trace_valid && trace_ready at an edge; the next entry appears after that edge.
  - Order is strict FIFO; pointers wrap modulo FIFO_DEPTH. Occupancy counter 0..FIFO_DEPTH.
- FIFO boundary cases:
  - Push when full with no pop: entry dropped, trace_overflow set (sticky until reset). store_count still increments.
  - Push and pop on the same edge while full: both happen, no overflow.
  - Push and pop on the same edge while not empty: occupancy unchanged.
  - trace_ready with FIFO empty: no effect.
- FIFO draining continues normally in terminal states.

Test Plan:
1. Reset 2 cycles. Store (0x40,7) at edge 3, then (100,25) at edge 6.
   -> pass=1, done=1 after edge 6; store_count=2; cycle_count=6 and frozen.
   -> trace_ready=1 drains (0x40,7) then (100,25), then trace_valid=0.
2. Store (100,9).
   -> fail=1. A later (100,25) is ignored: store_count stays 1, pass stays 0.
   Separately, a store to (104, any data) -> fail=1.
3. TIMEOUT_CYCLES=50, no stores -> timeout=1 after the 50th RUN edge, cycle_count=50.
   Rerun with (100,25) on edge 50 -> pass=1, timeout=0.
4. FIFO_DEPTH=4, trace_ready=0, six stores to addresses 0x10..0x60.
   -> store_count=6, trace_overflow=1.
   -> Drain yields 0x10, 0x20, 0x30, 0x40 in order, then trace_valid=0.
5. FIFO full with trace_ready=1 and a store on the same edge.
   -> trace_overflow stays 0, occupancy stays 4, the new entry is drained last.
6. Assert reset between clock edges mid-run with a non-empty FIFO.
   -> trace_valid, counters and flags go to 0 with no clock edge.
   -> After release, state is RUN and (100,25) -> pass=1.
